// File: rtl/hex_text_scroller.sv
// Scrolls a NUL-terminated text snapshot right-to-left across six active-low seven-segment digits.
// Optional: define SCROLL_PAUSE_EN to hold 3 extra ticks at pos 0 after each wrap and at scroll start.
module hex_text_scroller #(
  parameter int N_CHAR   = 100,
  parameter int N_DIGIT  = 6,
  parameter int TICK_DIV = 25000000,
  localparam int LEN_W   = $clog2(N_CHAR + 1),
  localparam int POS_W   = $clog2(N_CHAR + N_DIGIT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [N_CHAR*8-1:0]   buf_in,
  output logic [6:0]            hex5,
  output logic [6:0]            hex4,
  output logic [6:0]            hex3,
  output logic [6:0]            hex2,
  output logic [6:0]            hex1,
  output logic [6:0]            hex0,
  output logic                  busy,
  output logic [LEN_W-1:0]      msg_len,
  output logic [POS_W-1:0]      pos
);

  localparam int IDX_W = $clog2(N_CHAR);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SCROLL} state_t;

  state_t             state_q, state_d;
  logic [7:0]         snap [N_CHAR];
  logic [IDX_W-1:0]   scan_idx;
  logic [LEN_W-1:0]   msg_len_q;
  logic [POS_W-1:0]   pos_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [6:0]         seg_p1 [N_DIGIT];
  logic [6:0]         win_p0 [N_DIGIT];
`ifdef SCROLL_PAUSE_EN
  logic [1:0]         pause_q;
`endif

  logic [7:0]         scan_byte;
  logic               scan_done;
  logic [LEN_W-1:0]   found_len;
  logic [LEN_W-1:0]   len_sel;
  logic [POS_W-1:0]   last_pos;
  logic               tick;

  function automatic logic [6:0] font(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'h20 : ch;
    case (c)
      8'h30:        font = 7'h40;
      8'h31:        font = 7'h79;
      8'h32:        font = 7'h24;
      8'h33:        font = 7'h30;
      8'h34:        font = 7'h19;
      8'h35:        font = 7'h12;
      8'h36:        font = 7'h02;
      8'h37:        font = 7'h78;
      8'h38:        font = 7'h00;
      8'h39:        font = 7'h10;
      8'h41:        font = 7'h08;
      8'h42:        font = 7'h03;
      8'h43:        font = 7'h46;
      8'h44:        font = 7'h21;
      8'h45:        font = 7'h06;
      8'h46:        font = 7'h0E;
      8'h48:        font = 7'h09;
      8'h4C:        font = 7'h47;
      8'h50:        font = 7'h0C;
      8'h55:        font = 7'h41;
      8'h20, 8'h00: font = 7'h7F;
      default:      font = 7'h3F;
    endcase
  endfunction

  assign scan_byte = snap[scan_idx];
  assign scan_done = (state_q == SCAN) &&
                     ((scan_byte == 8'h00) || (scan_idx == IDX_W'(N_CHAR - 1)));
  assign found_len = (scan_byte == 8'h00) ? LEN_W'(scan_idx) : LEN_W'(N_CHAR);
  // On the SCAN exit edge the display must already reflect the freshly measured length.
  assign len_sel   = (state_q == SCAN) ? found_len : msg_len_q;
  assign last_pos  = POS_W'(msg_len_q) + POS_W'(N_DIGIT - 1);
  assign tick      = en && (cnt_q == CNT_W'(TICK_DIV - 1));

  // Stage p0: window of the virtual sequence (message + N_DIGIT spaces), wrapped by compare-and-subtract
  always_comb begin
    logic [POS_W-1:0] period;
    logic [POS_W-1:0] idx;
    logic [7:0]       ch;
    win_p0 = '{default: 7'h7F};
    period = POS_W'(len_sel) + POS_W'(N_DIGIT);
    idx    = '0;
    ch     = 8'h20;
    for (int k = 0; k < N_DIGIT; k++) begin
      idx = pos_q + POS_W'(k);
      if (idx >= period) idx = idx - period;
      ch = (idx < POS_W'(len_sel)) ? snap[idx[IDX_W-1:0]] : 8'h20;
      win_p0[k] = font(ch);
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = SCAN;
    end else begin
      case (state_q)
        SCAN:    if (scan_done) state_d = (found_len == '0) ? IDLE : SCROLL;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Stage p1: snapshot, scan, scroll position and registered display
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap      <= '{default: 8'h00};
      scan_idx  <= '0;
      msg_len_q <= '0;
      pos_q     <= '0;
      cnt_q     <= '0;
      seg_p1    <= '{default: 7'h7F};
`ifdef SCROLL_PAUSE_EN
      pause_q   <= 2'd0;
`endif
    end else if (load) begin
      for (int i = 0; i < N_CHAR; i++) snap[i] <= buf_in[8*i +: 8];
      scan_idx <= '0;
      pos_q    <= '0;
    end else begin
      case (state_q)
        SCAN: begin
          if (scan_done) begin
            msg_len_q <= found_len;
            cnt_q     <= '0;
            seg_p1    <= win_p0;
`ifdef SCROLL_PAUSE_EN
            pause_q   <= 2'd3;
`endif
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        SCROLL: begin
          seg_p1 <= win_p0;
          if (tick) begin
            cnt_q <= '0;
            // Messages that fit on the display stay static and left-aligned.
            if (msg_len_q > LEN_W'(N_DIGIT)) begin
`ifdef SCROLL_PAUSE_EN
              if (pause_q != 2'd0) begin
                pause_q <= pause_q - 2'd1;
              end else if (pos_q == last_pos) begin
                pos_q   <= '0;
                pause_q <= 2'd3;
              end else begin
                pos_q <= pos_q + POS_W'(1);
              end
`else
              if (pos_q == last_pos) pos_q <= '0;
              else                   pos_q <= pos_q + POS_W'(1);
`endif
            end
          end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign hex5    = seg_p1[0];
  assign hex4    = seg_p1[1];
  assign hex3    = seg_p1[2];
  assign hex2    = seg_p1[3];
  assign hex1    = seg_p1[4];
  assign hex0    = seg_p1[5];
  assign busy    = (state_q != IDLE);
  assign msg_len = msg_len_q;
  assign pos     = pos_q;

endmodule

// File: tb/tb_hex_text_scroller.sv
// Directed-plus-random bench for hex_text_scroller with a tick-count reference model (TICK_DIV=4).
`timescale 1ns/1ps
module tb_hex_text_scroller;
  localparam int N_CHAR  = 100;
  localparam int N_DIGIT = 6;
  localparam int TICK    = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [N_CHAR*8-1:0] buf_in = '0;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic        busy;
  logic [6:0]  msg_len;
  logic [6:0]  pos;
  logic [41:0] hexes;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  logic [7:0] m [N_CHAR];
  int mlen = 0;
  int prev_len = 0;
  int en_edges = 0;
  int prev_pos = 0;

  always #5 clk = ~clk;
  assign hexes = {hex5, hex4, hex3, hex2, hex1, hex0};

  hex_text_scroller #(.N_CHAR(N_CHAR), .N_DIGIT(N_DIGIT), .TICK_DIV(TICK)) dut (
    .clk(clk), .rst(rst_n), .en(en), .load(load), .buf_in(buf_in),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .busy(busy), .msg_len(msg_len), .pos(pos)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] font(input logic [7:0] ch);
    logic [7:0] c;
    c = (ch >= "a" && ch <= "z") ? ch - 8'd32 : ch;
    if (c >= "0" && c <= "9") begin
      logic [6:0] digits [10];
      digits = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      return digits[c - "0"];
    end
    case (c)
      "A": return 7'h08;
      "B": return 7'h03;
      "C": return 7'h46;
      "D": return 7'h21;
      "E": return 7'h06;
      "F": return 7'h0E;
      "H": return 7'h09;
      "L": return 7'h47;
      "P": return 7'h0C;
      "U": return 7'h41;
      " ", 8'h00: return 7'h7F;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [41:0] frame(input int p);
    logic [41:0] f;
    int per, i;
    logic [7:0] ch;
    per = mlen + N_DIGIT;
    f = '0;
    for (int k = 0; k < N_DIGIT; k++) begin
      i  = (p + k) % per;
      ch = (i < mlen) ? m[i] : " ";
      f[41 - 7*k -: 7] = font(ch);
    end
    return f;
  endfunction

  function automatic int exp_pos(input int ticks);
    int per, n;
    if (mlen <= N_DIGIT) return 0;
    per = mlen + N_DIGIT;
`ifdef SCROLL_PAUSE_EN
    n = ticks % (per + 3);
    return (n < 3) ? 0 : n - 3;
`else
    n = ticks % per;
    return n;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_str(input string s);
    for (int i = 0; i < N_CHAR; i++) m[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < s.len(); i++) m[i] = s[i];
    if (s.len() < N_CHAR) m[s.len()] = 8'h00;
    mlen = s.len();
  endtask

  task automatic pulse_load();
    for (int i = 0; i < N_CHAR; i++) buf_in[8*i +: 8] = m[i];
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_load();
    int s;
    pulse_load();
    s = (mlen >= N_CHAR) ? N_CHAR : mlen + 1;
    check("scan_busy", busy, 1);
    check("scan_pos", pos, 0);
    repeat (s - 1) step();
    if (prev_len != mlen) check("scan_len_hold", msg_len, prev_len);
    check("scan_busy_last", busy, 1);
    step();
    check("scan_len", msg_len, mlen);
    check("scan_exit_busy", busy, mlen != 0);
    check("scan_exit_pos", pos, 0);
    check("scan_exit_frame", hexes, frame(0));
    prev_len = mlen;
    en_edges = 0;
    prev_pos = 0;
  endtask

  task automatic run_scroll(input int cycles, input int en_pct);
    int ep;
    for (int t = 0; t < cycles; t++) begin
      en = ($urandom_range(0, 99) < en_pct);
      step();
      if (en) en_edges++;
      ep = exp_pos(en_edges / TICK);
      check("pos", pos, ep);
      check("frame", hexes, frame(prev_pos));
      check("busy", busy, mlen != 0);
      prev_pos = ep;
    end
  endtask

  task automatic rand_msg();
    string pool;
    int len;
    pool = " 0123456789AbCdEFHLPUabcdefhlpu?-!xz";
    len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : $urandom_range(7, 30);
    for (int i = 0; i < N_CHAR; i++) m[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < len; i++) m[i] = pool[$urandom_range(0, pool.len() - 1)];
    m[len] = 8'h00;
    mlen = len;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_hex", hexes, {42{1'b1}});
    check("rst_busy", busy, 0);
    check("rst_pos", pos, 0);
    check("rst_len", msg_len, 0);
    step();
    step();
    rst_n = 1'b1;

    set_str("0123456789");
    run_load();
    check("digits_frame0", hexes, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    run_scroll(70, 100);
    run_scroll(20, 0);
    run_scroll(20, 100);

    #3 rst_n = 1'b0;
    #1;
    check("midrst_hex", hexes, {42{1'b1}});
    check("midrst_busy", busy, 0);
    check("midrst_pos", pos, 0);
    check("midrst_len", msg_len, 0);
    step();
    rst_n = 1'b1;
    prev_len = 0;

    set_str("Ab?");
    run_load();
    check("short_frame", hexes, {7'h08, 7'h03, 7'h3F, 7'h7F, 7'h7F, 7'h7F});
    run_scroll(44, 100);

    set_str("");
    run_load();
    run_scroll(5, 100);

    set_str("HELLO PLACE 42");
    pulse_load();
    repeat (4) step();
    set_str("CAFE dEAd bEEF");
    run_load();
    run_scroll(30, 80);
    set_str("0123456789");
    run_load();
    run_scroll(12, 100);

    for (int i = 0; i < N_CHAR; i++) m[i] = "E";
    mlen = N_CHAR;
    run_load();
    run_scroll(440, 100);

    for (int r = 0; r < 8; r++) begin
      rand_msg();
      run_load();
      run_scroll($urandom_range(40, 130), 75);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
